// File: rtl/acc_outq.sv
// Output queue on the accumulator write-out path. Each we strobe pushes one
// 4-bit value, and the queue drains first-word-fall-through over valid/ready.
module acc_outq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [3:0]    acci,
    input  logic          clr,
    output logic [3:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf
);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic          pop;
    logic          push_ok;
    logic          drop;

    // Flags are decoded only from registered count, so they change only after clk.
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign ovf       = ovf_q;
    assign out_valid = ~empty;
    assign out_data  = empty ? 4'h0 : mem[rd_ptr];

    // A pop frees a slot in the same edge, so a full queue can still accept a push.
    assign pop     = out_valid & out_ready;
    assign push_ok = we & (~full | pop);
    assign drop    = we & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                count_q <= count_q + (AW+1)'(1);
            else if (pop && !push_ok)
                count_q <= count_q - (AW+1)'(1);
            if (drop)
                ovf_q <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; flush and reset only move pointers.
    always_ff @(posedge clk) begin
        if (!rst && !clr && push_ok)
            mem[wr_ptr] <= acci;
    end

endmodule

// File: tb/tb_acc_outq.sv
// Directed self-checking bench for acc_outq: reset, fill/drain, overflow,
// full push+pop, pointer wrap-around and flush.
module tb_acc_outq;

    logic       clk;
    logic       rst;
    logic       we;
    logic [3:0] acci;
    logic       clr;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    acc_outq #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .we(we), .acci(acci), .clr(clr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .full(full), .empty(empty), .count(count), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, step past the edge, then return to idle.
    task automatic applyStimulus(input logic pushEn, input logic [3:0] data, input logic readyEn, input logic clrEn);
        we        = pushEn;
        acci      = data;
        out_ready = readyEn;
        clr       = clrEn;
        @(posedge clk);
        #1;
        we        = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; acci = 4'h0; clr = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", 8'(count), 8'd0);
        checkOutput("rst_empty", 8'(empty), 8'd1);
        checkOutput("rst_full", 8'(full), 8'd0);
        checkOutput("rst_valid", 8'(out_valid), 8'd0);
        checkOutput("rst_data", 8'(out_data), 8'd0);
        checkOutput("rst_ovf", 8'(ovf), 8'd0);
        rst = 1'b0;

        // Mid-operation asynchronous reset
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        checkOutput("pre_rst_count", 8'(count), 8'd3);
        checkOutput("pre_rst_head", 8'(out_data), 8'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_count", 8'(count), 8'd0);
        checkOutput("async_rst_empty", 8'(empty), 8'd1);
        checkOutput("async_rst_valid", 8'(out_valid), 8'd0);
        checkOutput("async_rst_data", 8'(out_data), 8'd0);
        checkOutput("async_rst_ovf", 8'(ovf), 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        we = 1'b1; acci = 4'hA;
        #1;
        checkOutput("no_bypass_valid", 8'(out_valid), 8'd0);
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
        checkOutput("post_rst_valid", 8'(out_valid), 8'd1);
        checkOutput("post_rst_data", 8'(out_data), 8'hA);
        checkOutput("post_rst_count", 8'(count), 8'd1);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("post_rst_drained", 8'(empty), 8'd1);

        // In-order fill and drain
        for (int i = 1; i <= 4; i++)
            applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        checkOutput("fill_full", 8'(full), 8'd1);
        checkOutput("fill_count", 8'(count), 8'd4);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain_valid", 8'(out_valid), 8'd1);
            checkOutput("drain_data", 8'(out_data), 8'(i));
            applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        end
        checkOutput("drain_empty", 8'(empty), 8'd1);
        checkOutput("drain_valid_low", 8'(out_valid), 8'd0);

        // Overflow drops the push and sets the sticky flag
        for (int i = 5; i <= 8; i++)
            applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
        checkOutput("ovf_set", 8'(ovf), 8'd1);
        checkOutput("ovf_count", 8'(count), 8'd4);
        for (int i = 5; i <= 8; i++) begin
            checkOutput("ovf_drain_data", 8'(out_data), 8'(i));
            applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        end
        checkOutput("ovf_drain_empty", 8'(empty), 8'd1);
        checkOutput("ovf_sticky", 8'(ovf), 8'd1);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        checkOutput("ovf_clr", 8'(ovf), 8'd0);

        // Full queue accepts a push when the head is popped in the same cycle
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hD, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hE, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
        checkOutput("fpp_head", 8'(out_data), 8'hC);
        applyStimulus(1'b1, 4'h0, 1'b1, 1'b0);
        checkOutput("fpp_count", 8'(count), 8'd4);
        checkOutput("fpp_ovf", 8'(ovf), 8'd0);
        checkOutput("fpp_d0", 8'(out_data), 8'hD); applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("fpp_d1", 8'(out_data), 8'hE); applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("fpp_d2", 8'(out_data), 8'hF); applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("fpp_d3", 8'(out_data), 8'h0);
        checkOutput("fpp_d3_valid", 8'(out_valid), 8'd1);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("fpp_empty", 8'(empty), 8'd1);

        // Empty-queue corner cases: pop ignored, push with ready is push only
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("no_underflow", 8'(count), 8'd0);
        applyStimulus(1'b1, 4'h6, 1'b1, 1'b0);
        checkOutput("empty_push_ready", 8'(count), 8'd1);
        checkOutput("empty_push_data", 8'(out_data), 8'h6);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);

        // Wrap-around with single push/pop pairs
        for (int v = 0; v < 10; v++) begin
            applyStimulus(1'b1, 4'(v), 1'b0, 1'b0);
            checkOutput("wrap_data", 8'(out_data), 8'(v));
            applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        end
        checkOutput("wrap_empty", 8'(empty), 8'd1);

        // Flush wins over a simultaneous push and pop
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        checkOutput("flush_pre_count", 8'(count), 8'd2);
        applyStimulus(1'b1, 4'h7, 1'b1, 1'b1);
        checkOutput("flush_count", 8'(count), 8'd0);
        checkOutput("flush_empty", 8'(empty), 8'd1);
        checkOutput("flush_data", 8'(out_data), 8'd0);
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        checkOutput("post_flush_head", 8'(out_data), 8'h3);
        checkOutput("post_flush_count", 8'(count), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
